// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared definitions for the register-file write-port arbiter.
//   DW_DEF / AW_DEF  : default data and address widths
//   SRC_WB / SRC_LLU : encoding of rf_src (pipeline vs long-latency unit)
//   state_e          : arbiter FSM states
package rf_arb_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  localparam logic SRC_WB  = 1'b0;
  localparam logic SRC_LLU = 1'b1;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_e;

endpackage

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: synchronous FIFO buffering long-latency {addr, data} results.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : enqueue push_data (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   push_data  : entry to enqueue
//   full/empty : occupancy flags
//   count      : number of valid entries (0..DEPTH)
//   head       : oldest entry, valid while !empty
module rf_wr_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so clearing the array would only cost area.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between
// the pipeline writeback and a long-latency unit (mul/div). Long-latency
// results are buffered; a buffered head that waits STARVE_LIMIT un-granted
// cycles forces a one-cycle pipeline stall during which it is written.
//   clkd, rst_n            : clock, asynchronous active-low reset
//   wb_we/wb_addr/wb_data  : pipeline writeback request
//   llu_valid/addr/data    : long-latency result, accepted when llu_ready
//   llu_ready              : !full (combinational)
//   stall                  : registered one-cycle pipeline freeze
//   rf_we/rf_addr/rf_data  : registered register-file write port
//   rf_src                 : registered source of the write (SRC_WB/SRC_LLU)
//   pend_count             : buffered result count
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int AW           = AW_DEF,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clkd,
  input  logic                        rst_n,
  input  logic                        wb_we,
  input  logic [AW-1:0]               wb_addr,
  input  logic [DW-1:0]               wb_data,
  input  logic                        llu_valid,
  input  logic [AW-1:0]               llu_addr,
  input  logic [DW-1:0]               llu_data,
  output logic                        llu_ready,
  output logic                        stall,
  output logic                        rf_we,
  output logic [AW-1:0]               rf_addr,
  output logic [DW-1:0]               rf_data,
  output logic                        rf_src,
  output logic [$clog2(FIFO_DEPTH):0] pend_count
);

  state_e r_state;
  state_e w_state_nxt;

  logic [3:0]       r_starve;
  logic [3:0]       w_starve_nxt;

  logic             w_full;
  logic             w_empty;
  logic [AW+DW-1:0] w_head;
  logic             w_wb_active;
  logic             w_push;
  logic             w_pop;
  logic             w_grant_wb;

  logic             r_stall;
  logic             r_rf_we;
  logic [AW-1:0]    r_rf_addr;
  logic [DW-1:0]    r_rf_data;
  logic             r_rf_src;

  assign w_wb_active = wb_we && (wb_addr != '0);
  assign llu_ready   = !w_full;
  // Register-0 results complete the handshake but are never buffered.
  assign w_push      = llu_valid && !w_full && (llu_addr != '0);

  rf_wr_fifo #(
    .W     (AW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clkd),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data ({llu_addr, llu_data}),
    .full      (w_full),
    .empty     (w_empty),
    .count     (pend_count),
    .head      (w_head)
  );

  // NOTE: every signal assigned here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    w_pop        = 1'b0;
    w_grant_wb   = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (w_wb_active)   w_grant_wb = 1'b1;
        else if (!w_empty) w_pop      = 1'b1;
        // Force only when the head is still waiting this cycle; if the
        // pipeline went idle and the head pops anyway, no stall is needed.
        if (w_pop || w_empty)                     w_starve_nxt = '0;
        else if (r_starve == 4'(STARVE_LIMIT))    w_state_nxt  = ST_FORCE;
        else                                      w_starve_nxt = r_starve + 4'd1;
      end
      ST_FORCE: begin
        // Entry into FORCE guarantees a buffered head; pipeline is ignored.
        w_pop        = !w_empty;
        w_starve_nxt = '0;
        w_state_nxt  = ST_NORMAL;
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clkd or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_NORMAL;
      r_starve  <= '0;
      r_stall   <= 1'b0;
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
      r_rf_src  <= SRC_WB;
    end else begin
      r_state   <= w_state_nxt;
      r_starve  <= w_starve_nxt;
      r_stall   <= (w_state_nxt == ST_FORCE);
      r_rf_we   <= w_grant_wb || w_pop;
      if (w_grant_wb) begin
        r_rf_addr <= wb_addr;
        r_rf_data <= wb_data;
        r_rf_src  <= SRC_WB;
      end else if (w_pop) begin
        r_rf_addr <= w_head[AW+DW-1:DW];
        r_rf_data <= w_head[DW-1:0];
        r_rf_src  <= SRC_LLU;
      end else begin
        r_rf_addr <= '0;
        r_rf_data <= '0;
        r_rf_src  <= SRC_WB;
      end
    end
  end

  assign stall   = r_stall;
  assign rf_we   = r_rf_we;
  assign rf_addr = r_rf_addr;
  assign rf_data = r_rf_data;
  assign rf_src  = r_rf_src;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter
// (DW=32, AW=5, FIFO_DEPTH=2, STARVE_LIMIT=4). Inputs change 1 time unit
// after the rising edge; outputs are checked at the same point.
module tb_rf_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clkd = 1'b0;
  logic          rst_n;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          llu_valid;
  logic [AW-1:0] llu_addr;
  logic [DW-1:0] llu_data;
  logic          llu_ready;
  logic          stall;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          rf_src;
  logic [1:0]    pend_count;

  int n_cmp = 0;
  int n_bad = 0;

  rf_write_arbiter #(
    .DW           (DW),
    .AW           (AW),
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clkd       (clkd),
    .rst_n      (rst_n),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .llu_valid  (llu_valid),
    .llu_addr   (llu_addr),
    .llu_data   (llu_data),
    .llu_ready  (llu_ready),
    .stall      (stall),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rf_src     (rf_src),
    .pend_count (pend_count)
  );

  always #5 clkd = ~clkd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkd);
    #1;
  endtask

  task automatic drive_wb(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_we   = we;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic drive_llu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    llu_valid = v;
    llu_addr  = a;
    llu_data  = d;
  endtask

  task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic src);
    check({tag, "_we"},   rf_we,   1'b1);
    check({tag, "_addr"}, rf_addr, a);
    check({tag, "_data"}, rf_data, d);
    check({tag, "_src"},  rf_src,  src);
  endtask

  // Starvation scenario: pipeline address presented in c0..c9 (0 = idle),
  // and the write expected on the port in c1..c9.
  int unsigned st_wb    [10] = '{1, 2, 3, 4, 5, 6, 7, 7, 8, 0};
  int unsigned st_addr  [9]  = '{1, 2, 3, 4, 5, 6, 9, 7, 8};
  int unsigned st_src   [9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
  int unsigned st_stall [9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
  int unsigned st_cnt   [9]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};

  initial begin
    rst_n = 1'b0;
    drive_wb(1'b0, '0, '0);
    drive_llu(1'b0, '0, '0);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_we",    rf_we, 1'b0);
    check("rst_addr",  rf_addr, '0);
    check("rst_data",  rf_data, '0);
    check("rst_src",   rf_src, 1'b0);
    check("rst_pend",  pend_count, 2'd0);
    check("rst_ready", llu_ready, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;

    // Pipeline write lands one cycle later for exactly one cycle.
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    check_write("wb5", 5'd5, 32'hDEAD_BEEF, 1'b0);
    drive_wb(1'b0, '0, '0);
    tick();
    check("wb5_once", rf_we, 1'b0);
    drive_wb(1'b1, 5'd0, 32'h1111_1111);
    tick();
    check("wb0_drop", rf_we, 1'b0);
    drive_wb(1'b0, '0, '0);
    tick();

    // Idle pipeline: LLU result written two cycles after the transfer.
    drive_llu(1'b1, 5'd7, 32'h1234_5678);
    check("llu7_ready", llu_ready, 1'b1);
    tick();
    drive_llu(1'b0, '0, '0);
    check("llu7_pend1", pend_count, 2'd1);
    check("llu7_nowe",  rf_we, 1'b0);
    tick();
    check_write("llu7", 5'd7, 32'h1234_5678, 1'b1);
    check("llu7_pend0", pend_count, 2'd0);

    // LLU result for register 0: handshake completes, nothing buffered.
    drive_llu(1'b1, 5'd0, 32'hCAFE_0000);
    check("llu0_ready", llu_ready, 1'b1);
    tick();
    drive_llu(1'b0, '0, '0);
    check("llu0_pend", pend_count, 2'd0);
    check("llu0_we1",  rf_we, 1'b0);
    tick();
    check("llu0_we2",  rf_we, 1'b0);

    // Starvation: continuous pipeline writes, one LLU result buffered.
    drive_wb(1'b1, AW'(st_wb[0]), 32'hA000_0000 | st_wb[0]);
    drive_llu(1'b1, 5'd9, 32'h0BAD_F00D);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) drive_llu(1'b0, '0, '0);
      check_write($sformatf("starve_c%0d", c), AW'(st_addr[c-1]),
                  (st_src[c-1] != 0) ? 32'h0BAD_F00D : (32'hA000_0000 | st_addr[c-1]),
                  st_src[c-1][0]);
      check($sformatf("starve_c%0d_stall", c), stall, st_stall[c-1][0]);
      check($sformatf("starve_c%0d_pend", c), pend_count, 2'(st_cnt[c-1]));
      if (st_wb[c] != 0) drive_wb(1'b1, AW'(st_wb[c]), 32'hA000_0000 | st_wb[c]);
      else               drive_wb(1'b0, '0, '0);
    end
    tick();
    check("starve_idle_we", rf_we, 1'b0);

    // FIFO full: third result is held until a slot frees.
    drive_wb(1'b1, 5'd10, 32'h0000_1010);
    drive_llu(1'b1, 5'd11, 32'h0000_000A);
    check("full_d0_ready", llu_ready, 1'b1);
    tick();
    check("full_d1_pend",  pend_count, 2'd1);
    check("full_d1_ready", llu_ready, 1'b1);
    drive_llu(1'b1, 5'd12, 32'h0000_000B);
    tick();
    check("full_d2_pend",  pend_count, 2'd2);
    check("full_d2_ready", llu_ready, 1'b0);
    drive_llu(1'b1, 5'd13, 32'h0000_000C);
    for (int d = 3; d <= 6; d++) begin
      tick();
      check($sformatf("full_d%0d_ready", d), llu_ready, 1'b0);
      check($sformatf("full_d%0d_stall", d), stall, (d == 6) ? 1'b1 : 1'b0);
      check_write($sformatf("full_d%0d", d), 5'd10, 32'h0000_1010, 1'b0);
    end
    tick();
    check_write("full_d7", 5'd11, 32'h0000_000A, 1'b1);
    check("full_d7_pend",  pend_count, 2'd1);
    check("full_d7_ready", llu_ready, 1'b1);
    check("full_d7_stall", stall, 1'b0);
    tick();
    check_write("full_d8", 5'd10, 32'h0000_1010, 1'b0);
    check("full_d8_pend",  pend_count, 2'd2);
    drive_llu(1'b0, '0, '0);
    drive_wb(1'b0, '0, '0);
    tick();
    check_write("full_d9", 5'd12, 32'h0000_000B, 1'b1);
    check("full_d9_pend", pend_count, 2'd1);
    tick();
    check_write("full_d10", 5'd13, 32'h0000_000C, 1'b1);
    check("full_d10_pend", pend_count, 2'd0);
    tick();
    check("full_d11_we", rf_we, 1'b0);

    // Reset asserted during FORCE with two results buffered.
    drive_wb(1'b1, 5'd3, 32'h0000_0303);
    drive_llu(1'b1, 5'd14, 32'h0000_000E);
    tick();
    drive_llu(1'b1, 5'd15, 32'h0000_000F);
    tick();
    drive_llu(1'b0, '0, '0);
    repeat (4) tick();
    check("mrst_stall_pre", stall, 1'b1);
    check("mrst_pend_pre",  pend_count, 2'd2);
    rst_n = 1'b0;
    drive_wb(1'b0, '0, '0);
    #1;
    check("mrst_stall", stall, 1'b0);
    check("mrst_we",    rf_we, 1'b0);
    check("mrst_addr",  rf_addr, '0);
    check("mrst_pend",  pend_count, 2'd0);
    check("mrst_ready", llu_ready, 1'b1);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_pend",  pend_count, 2'd0);
    check("post_rst_ready", llu_ready, 1'b1);
    check("post_rst_we",    rf_we, 1'b0);
    check("post_rst_stall", stall, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Register-file write-port arbiter sitting between the WB stage and the register file's single write port. It shares that port between the in-order pipeline writeback and a long-latency unit (multiply/divide), buffering long-latency results in a small FIFO. It forces a one-cycle pipeline stall when a buffered result has waited too long. All write-port outputs are registered, so pipeline writebacks keep the existing one-cycle WB register latency.

## Interface
- DW, 32, register data width
- AW, 5, register address width
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive un-granted cycles with FIFO non-empty before a forced grant (1..15)

- clkd  in  1  single clock (the selected clkd phase bit from top level)
- rst_n  in  1  reset, asynchronous, active-low
- wb_we  in  1  pipeline writeback enable (WriteReg)
- wb_addr  in  AW  pipeline destination register
- wb_data  in  DW  pipeline writeback data (post MemToReg mux)
- llu_valid  in  1  long-latency result valid
- llu_addr  in  AW  long-latency destination register
- llu_data  in  DW  long-latency result
- llu_ready  out  1  result accepted when llu_valid && llu_ready
- stall  out  1  registered; freezes pipeline WB inputs for one cycle
- rf_we  out  1  registered register-file write enable
- rf_addr  out  AW  registered write address
- rf_data  out  DW  registered write data
- rf_src  out  1  registered source of the current write: 0 = pipeline, 1 = long-latency unit
- pend_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Pipeline request is active when wb_we=1 and wb_addr≠0. Writes to register 0 are dropped from either source.
- Long-latency handshake: llu_ready = !full, derived combinationally from the FIFO count.
  - A transfer with llu_addr=0 is accepted and discarded (not enqueued).
- FSM states:
  - NORMAL:
    - Grant the pipeline if it is active; otherwise pop the FIFO head if the FIFO is non-empty.
    - The starve counter increments each cycle the FIFO is non-empty and not popped. It clears on any pop or when the FIFO is empty.
    - When the counter reaches STARVE_LIMIT: next state is FORCE, and stall is registered high.
  - FORCE (exactly one cycle):
    - stall=1. Pop the FIFO head unconditionally; the pipeline request is ignored.
    - Upstream holds wb_* stable while stall=1, and the held request is granted in the following cycle.
    - Counter clears; next state is NORMAL; stall is registered low.
- Push and pop in the same cycle are both allowed when not full. When full, llu_ready=0 even if a pop occurs that cycle.
- No WAW checking: issue logic guarantees no pipeline write targets a register with an in-flight long-latency write.
- Reset (any time, including mid-FORCE):
  - All outputs registered low; rf_addr=0, rf_data=0, rf_src=0, stall=0.
  - FIFO emptied, buffered results lost, counter=0, state=NORMAL.
  - After reset: llu_ready=1, pend_count=0.

## Timing
- Pipeline request in cycle N: rf_we/rf_addr/rf_data valid in cycle N+1, for exactly one cycle.
- Long-latency transfer in cycle N: enqueued at the N→N+1 edge. Earliest rf_we is in cycle N+2 (pop in N+1).
- Worst-case buffered wait: a head entry is popped no later than STARVE_LIMIT+1 cycles after it becomes head.
- stall rises in the cycle after the counter hits STARVE_LIMIT and stays high one cycle.
- pend_count updates on the clock edge following push/pop.

## Structure
- Package rf_arb_pkg: DW/AW defaults, rf_src encoding (SRC_WB=0, SRC_LLU=1), state enum (ST_NORMAL, ST_FORCE).
- Sub-module rf_wr_fifo: synchronous FIFO of {addr, data}, FIFO_DEPTH entries, asynchronous active-low reset.
  - Ports: push, pop, full, empty, count, head.
- The top level holds the FSM, starve counter, grant mux and output registers.

## Test plan
- Reset mid-FORCE with 2 entries buffered → stall=0, rf_we=0 immediately; after release pend_count=0, llu_ready=1.
- wb_we=1, wb_addr=5, wb_data=0xDEADBEEF in cycle 10 → cycle 11: rf_we=1, rf_addr=5, rf_data=0xDEADBEEF, rf_src=0. wb_addr=0 → rf_we stays 0.
- Idle pipeline; llu transfer addr=7, data=0x12345678 in cycle 20 → cycle 22: rf_we=1, rf_addr=7, rf_src=1; pend_count returns to 0.
- Pipeline writes every cycle; one LLU result arrives (STARVE_LIMIT=4) → after 4 un-granted cycles, stall=1 for one cycle and the LLU result is written. The held pipeline write lands the next cycle and no pipeline write is lost.
- Two LLU transfers fill the FIFO (depth 2) → llu_ready=0; a third llu_valid is held until the first pop. The third result is accepted, and no entry is dropped or duplicated.
- LLU transfer with llu_addr=0 → llu_ready=1 during the transfer, pend_count unchanged, no rf_we.
